// File: rtl/router_pkt_rx.sv
// Drains one router output port: reads header/payload/parity, checks parity and address, reports per packet.
// Header costs one bubble cycle, then one byte per cycle; rd_en is issued only while enable && valid_out.
module router_pkt_rx #(
  parameter logic [1:0]  PORT_ID = 2'd2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        valid_out,
  input  logic [7:0]  data_out,
  output logic        rd_en,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        pkt_done,
  output logic [5:0]  pkt_len,
  output logic [1:0]  pkt_addr,
  output logic        parity_err,
  output logic        addr_err,
  output logic        timeout_err,
  output logic [15:0] pkt_count,
  output logic        rx_busy
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HDR_WAIT, PAYLOAD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rd_pend;
  logic [6:0]      r_req_cnt;
  logic [5:0]      r_rcv_cnt;
  logic [7:0]      r_acc;
  logic [IW-1:0]   r_idle_cnt;

  logic            w_rd;
  logic            w_is_par;
  logic            w_idle;
  logic            w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_is_par    = 1'b0;
    w_idle      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && valid_out) begin
          w_rd        = 1'b1;
          w_state_nxt = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        // len payload reads plus one parity read
        w_rd      = enable && valid_out && (r_req_cnt < ({1'b0, pkt_len} + 7'd1));
        w_is_par  = r_rd_pend && (r_rcv_cnt == pkt_len);
        w_idle    = !w_rd && !r_rd_pend;
        w_timeout = w_idle && (r_idle_cnt == IW'(TIMEOUT - 1));
        if (w_is_par || w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset must silence the strobe even though IDLE would otherwise read.
  assign rd_en   = w_rd && rstn;
  assign rx_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_rd_pend   <= 1'b0;
      r_req_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_acc       <= '0;
      r_idle_cnt  <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      pkt_addr    <= '0;
      parity_err  <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_pend   <= w_rd;
      byte_valid  <= 1'b0;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;

      if (r_state == HDR_WAIT) begin
        byte_valid <= 1'b1;
        byte_data  <= data_out;
        pkt_len    <= data_out[7:2];
        pkt_addr   <= data_out[1:0];
        r_acc      <= data_out;
        addr_err   <= (data_out[1:0] != PORT_ID);
        parity_err <= 1'b0;
        r_req_cnt  <= '0;
        r_rcv_cnt  <= '0;
      end

      if (r_state == PAYLOAD) begin
        if (w_rd) begin
          r_req_cnt <= r_req_cnt + 7'd1;
        end
        if (r_rd_pend) begin
          byte_valid <= 1'b1;
          byte_data  <= data_out;
          r_rcv_cnt  <= r_rcv_cnt + 6'd1;
          if (w_is_par) begin
            parity_err <= (data_out != r_acc);
            pkt_done   <= 1'b1;
            if (pkt_count != 16'hFFFF) begin
              pkt_count <= pkt_count + 16'd1;
            end
          end else begin
            r_acc <= r_acc ^ data_out;
          end
        end
        if (w_timeout) begin
          timeout_err <= 1'b1;
        end
      end

      if (w_idle && !w_timeout) begin
        r_idle_cnt <= r_idle_cnt + IW'(1);
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Directed bench for router_pkt_rx: router port FIFO model, byte and packet scoreboards.
module tb_router_pkt_rx;

  localparam logic [1:0] PORT_ID = 2'd2;
  localparam int         TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        rd_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        pkt_done;
  logic [5:0]  pkt_len;
  logic [1:0]  pkt_addr;
  logic        parity_err;
  logic        addr_err;
  logic        timeout_err;
  logic [15:0] pkt_count;
  logic        rx_busy;

  always #5 clk = ~clk;

  router_pkt_rx #(.PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .valid_out(valid_out), .data_out(data_out),
    .rd_en(rd_en), .byte_valid(byte_valid), .byte_data(byte_data), .pkt_done(pkt_done),
    .pkt_len(pkt_len), .pkt_addr(pkt_addr), .parity_err(parity_err), .addr_err(addr_err),
    .timeout_err(timeout_err), .pkt_count(pkt_count), .rx_busy(rx_busy)
  );

  typedef struct {
    logic        perr;
    logic        aerr;
    logic [5:0]  len;
    logic [1:0]  addr;
    logic [15:0] cnt;
  } exp_pkt_t;

  logic [7:0]  router_q[$];
  logic [7:0]  exp_bytes[$];
  exp_pkt_t    exp_pkts[$];
  logic [15:0] exp_count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_cnt, bv_cnt, done_cnt, to_cnt;
  int   first_rd_cyc, done_cyc, last_bv_cyc, to_cyc;
  logic prev_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Router port FIFO: data appears the cycle after the read strobe.
  initial begin
    valid_out = 1'b0;
    data_out  = 8'h00;
    prev_rd   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_rd && router_q.size() > 0) data_out = router_q.pop_front();
      valid_out = (router_q.size() > 0);
      @(negedge clk);
      prev_rd = rd_en;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_guard_en_vld", {30'd0, enable, valid_out}, 32'd3);
      end
      if (byte_valid) begin
        bv_cnt++;
        last_bv_cyc = cyc;
        check("byte_expected", exp_bytes.size() > 0, 1);
        if (exp_bytes.size() > 0) check("byte_data", byte_data, exp_bytes.pop_front());
      end
      if (pkt_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("pkt_expected", exp_pkts.size() > 0, 1);
        if (exp_pkts.size() > 0) begin
          exp_pkt_t e;
          e = exp_pkts.pop_front();
          check("parity_err", parity_err, e.perr);
          check("addr_err", addr_err, e.aerr);
          check("pkt_len", pkt_len, e.len);
          check("pkt_addr", pkt_addr, e.addr);
          check("pkt_count", pkt_count, e.cnt);
        end
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_stats();
    rd_cnt = 0; bv_cnt = 0; done_cnt = 0; to_cnt = 0;
    first_rd_cyc = -1; done_cyc = 0; last_bv_cyc = 0; to_cyc = 0;
  endtask

  task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] flip, input int n_push);
    logic [7:0] pkt[$];
    logic [7:0] par;
    logic [7:0] b;
    exp_pkt_t   e;
    pkt.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom_range(0, 255));
      pkt.push_back(b);
      par = par ^ b;
    end
    pkt.push_back(par ^ flip);
    if (n_push > pkt.size()) n_push = pkt.size();
    for (int i = 0; i < n_push; i++) begin
      router_q.push_back(pkt[i]);
      exp_bytes.push_back(pkt[i]);
    end
    if (n_push == pkt.size()) begin
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      e.perr = (flip != 8'h00);
      e.aerr = (hdr[1:0] != PORT_ID);
      e.len  = hdr[7:2];
      e.addr = hdr[1:0];
      e.cnt  = exp_count;
      exp_pkts.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    step(3);
  endtask

  task automatic check_pkt(input string tag, input int len, input bit check_span);
    check({tag, "_rd_cnt"}, rd_cnt, len + 2);
    check({tag, "_bv_cnt"}, bv_cnt, len + 2);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_bytes_left"}, exp_bytes.size(), 0);
    check({tag, "_busy_after"}, rx_busy, 1'b0);
    // header read, one bubble, len+1 back-to-back reads, capture, registered pulse
    if (check_span) check({tag, "_span"}, done_cyc - first_rd_cyc, len + 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_byte_valid"}, byte_valid, 1'b0);
    check({tag, "_byte_data"}, byte_data, 8'h00);
    check({tag, "_pkt_done"}, pkt_done, 1'b0);
    check({tag, "_len_addr"}, {pkt_len, pkt_addr}, 8'h00);
    check({tag, "_errs"}, {parity_err, addr_err, timeout_err}, 3'b000);
    check({tag, "_pkt_count"}, pkt_count, 16'h0000);
    check({tag, "_rx_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    rstn      = 1'b0;
    enable    = 1'b1;
    exp_count = 16'd0;
    clr_stats();
    step(3);
    check_reset_outputs("init");
    rstn = 1'b1;
    step(2);

    clr_stats();
    load_pkt(8'h16, 8'h00, 99);
    wait_done("good", 40);
    check_pkt("good", 5, 1'b1);

    clr_stats();
    load_pkt(8'h16, 8'h01, 99);
    wait_done("bad_par", 40);
    check_pkt("bad_par", 5, 1'b1);

    clr_stats();
    load_pkt(8'h02, 8'h00, 99);
    wait_done("zero_len", 40);
    check_pkt("zero_len", 0, 1'b1);

    clr_stats();
    load_pkt(8'h15, 8'h00, 99);
    wait_done("bad_addr", 40);
    check_pkt("bad_addr", 5, 1'b1);

    clr_stats();
    load_pkt(8'hFE, 8'h00, 99);
    wait_done("max_len", 200);
    check_pkt("max_len", 63, 1'b1);

    // Router runs dry after three payload bytes
    clr_stats();
    load_pkt(8'h16, 8'h00, 4);
    n = 0;
    while (to_cnt == 0 && n < 300) begin
      step(1);
      n++;
    end
    check("stall_timeout_seen", to_cnt, 1);
    gap = to_cyc - last_bv_cyc;
    check("stall_timeout_gap", (gap >= TIMEOUT) && (gap <= TIMEOUT + 1), 1'b1);
    step(3);
    check("stall_timeout_pulse", to_cnt, 1);
    check("stall_no_done", done_cnt, 0);
    check("stall_bytes", bv_cnt, 4);
    check("stall_idle", rx_busy, 1'b0);
    check("stall_count_held", pkt_count, exp_count);

    clr_stats();
    load_pkt(8'h22, 8'h00, 99);
    n = 0;
    while (bv_cnt < 4 && n < 50) begin
      step(1);
      n++;
    end
    check("toggle_progress", bv_cnt >= 4, 1'b1);
    enable = 1'b0;
    step(10);
    check("toggle_busy_paused", rx_busy, 1'b1);
    check("toggle_no_done_paused", done_cnt, 0);
    enable = 1'b1;
    wait_done("toggle", 60);
    check_pkt("toggle", 8, 1'b0);

    clr_stats();
    load_pkt(8'h16, 8'h00, 99);
    n = 0;
    while (bv_cnt < 3 && n < 50) begin
      step(1);
      n++;
    end
    check("rst_mid_progress", bv_cnt >= 3, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid_async");
    step(2);
    check_reset_outputs("rst_mid_held");
    router_q.delete();
    exp_bytes.delete();
    exp_pkts.delete();
    exp_count = 16'd0;
    step(2);
    rstn = 1'b1;
    step(2);
    clr_stats();
    load_pkt(8'h16, 8'h00, 99);
    wait_done("post_rst", 40);
    check_pkt("post_rst", 5, 1'b1);
    check("post_rst_count", pkt_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
